// File: rtl/uart_console_master.sv
// uart_console_master
// Drives a memory-mapped UART over a single-outstanding native bus. After
// reset it programs the baud divisor and enables TX/RX. It then polls for
// received bytes, decodes console control bytes (ENQ/EOT/FRX/FTX) into event
// pulses, forwards other bytes as character pulses, and sends upstream bytes
// on request. The first ENQ gets a one-time reply byte.
//
// Build option: define CONSOLE_LD_FW_EN to make the ENQ reply FRX (0x07),
// which asks the host for a firmware upload. Without it the reply is ACK (0x06).
//
// Bus handshake: a request is launched by raising uart_valid together with
// uart_addr/uart_wdata/uart_wstrb. All four hold steady until the cycle in
// which uart_ready=1; that is the only cycle in which uart_rdata is sampled.
// uart_valid drops on the following cycle, so there is at most one access in
// flight. Reads carry wstrb=0 and writes carry wstrb=4'hF.
// Upstream byte handshake: tx_ready pulses for one cycle in the IDLE cycle
// that latches tx_data. A byte on tx_valid is held off (not lost) while the
// master is busy, initialising or halted.
module uart_console_master #(
  parameter int DATA_W      = 32,
  parameter int UART_ADDR_W = 3,
  parameter int DIV         = 434
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   uart_valid,
  output logic [UART_ADDR_W-1:0] uart_addr,
  output logic [DATA_W-1:0]      uart_wdata,
  output logic [3:0]             uart_wstrb,
  input  logic [DATA_W-1:0]      uart_rdata,
  input  logic                   uart_ready,
  input  logic                   tx_valid,
  input  logic [7:0]             tx_data,
  output logic                   tx_ready,
  output logic                   char_valid,
  output logic [7:0]             char_data,
  output logic                   evt_enq,
  output logic                   evt_frx,
  output logic                   evt_ftx,
  output logic                   done,
  output logic                   connected,
  output logic [3:0]             o_dbg_state
);

  // UART register map
  localparam logic [UART_ADDR_W-1:0] REG_DIV     = UART_ADDR_W'(0);
  localparam logic [UART_ADDR_W-1:0] REG_TXEN    = UART_ADDR_W'(1);
  localparam logic [UART_ADDR_W-1:0] REG_RXEN    = UART_ADDR_W'(2);
  localparam logic [UART_ADDR_W-1:0] REG_TXBUSY  = UART_ADDR_W'(3);
  localparam logic [UART_ADDR_W-1:0] REG_RXREADY = UART_ADDR_W'(4);
  localparam logic [UART_ADDR_W-1:0] REG_TXDATA  = UART_ADDR_W'(5);
  localparam logic [UART_ADDR_W-1:0] REG_RXDATA  = UART_ADDR_W'(6);

  // Console control bytes
  localparam logic [7:0] CH_EOT = 8'h04;
  localparam logic [7:0] CH_ENQ = 8'h05;
  localparam logic [7:0] CH_FRX = 8'h07;
  localparam logic [7:0] CH_FTX = 8'h08;

`ifdef CONSOLE_LD_FW_EN
  localparam logic [7:0] REPLY_BYTE = 8'h07;
`else
  localparam logic [7:0] REPLY_BYTE = 8'h06;
`endif

  localparam logic [3:0] STRB_RD = 4'h0;
  localparam logic [3:0] STRB_WR = 4'hF;

  typedef enum logic [3:0] {
    S_INIT_DIV  = 4'd0,
    S_INIT_TXEN = 4'd1,
    S_INIT_RXEN = 4'd2,
    S_IDLE      = 4'd3,
    S_TX_POLL   = 4'd4,
    S_TX_WR     = 4'd5,
    S_RX_POLL   = 4'd6,
    S_RX_RD     = 4'd7,
    S_DECODE    = 4'd8,
    S_HALT      = 4'd9
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  // Registered bus request
  logic                   r_valid;
  logic [UART_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [3:0]             r_wstrb;

  // Datapath and sticky flags
  logic [7:0]             r_tx_byte;
  logic                   r_tx_is_reply;
  logic [7:0]             r_rx_byte;
  logic                   r_pending;
  logic                   r_enq_seen;
  logic                   r_done;
  logic                   r_connected;

  // Decoded per-cycle controls
  logic                   w_complete;
  logic                   w_bus_state;
  logic                   w_issue;
  logic [UART_ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0]      w_req_wdata;
  logic [3:0]             w_req_wstrb;
  logic                   w_sel_tx;
  logic                   w_sel_reply;
  logic                   w_latch_rx;
  logic                   w_set_pending;
  logic                   w_set_connected;
  logic                   w_set_done;
  logic                   w_evt_enq;
  logic                   w_evt_frx;
  logic                   w_evt_ftx;
  logic                   w_char_valid;

  // An access finishes in the cycle the slave answers an outstanding request.
  assign w_complete = r_valid & uart_ready;

  // A bus state launches its request whenever nothing is outstanding.
  assign w_issue = w_bus_state & ~r_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT_DIV;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic, request contents for the current state, decode actions
  always_comb begin
    w_state_nxt     = r_state;
    w_bus_state     = 1'b0;
    w_req_addr      = '0;
    w_req_wdata     = '0;
    w_req_wstrb     = STRB_RD;
    w_sel_tx        = 1'b0;
    w_sel_reply     = 1'b0;
    w_latch_rx      = 1'b0;
    w_set_pending   = 1'b0;
    w_set_connected = 1'b0;
    w_set_done      = 1'b0;
    w_evt_enq       = 1'b0;
    w_evt_frx       = 1'b0;
    w_evt_ftx       = 1'b0;
    w_char_valid    = 1'b0;
    case (r_state)
      S_INIT_DIV: begin
        w_bus_state = 1'b1;
        w_req_addr  = REG_DIV;
        w_req_wdata = DATA_W'(DIV);
        w_req_wstrb = STRB_WR;
        if (w_complete) w_state_nxt = S_INIT_TXEN;
      end
      S_INIT_TXEN: begin
        w_bus_state = 1'b1;
        w_req_addr  = REG_TXEN;
        w_req_wdata = DATA_W'(1);
        w_req_wstrb = STRB_WR;
        if (w_complete) w_state_nxt = S_INIT_RXEN;
      end
      S_INIT_RXEN: begin
        w_bus_state = 1'b1;
        w_req_addr  = REG_RXEN;
        w_req_wdata = DATA_W'(1);
        w_req_wstrb = STRB_WR;
        if (w_complete) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // Owed reply beats upstream data, which beats polling the receiver.
        if (r_pending) begin
          w_sel_reply = 1'b1;
          w_state_nxt = S_TX_POLL;
        end else if (tx_valid) begin
          w_sel_tx    = 1'b1;
          w_state_nxt = S_TX_POLL;
        end else begin
          w_state_nxt = S_RX_POLL;
        end
      end
      S_TX_POLL: begin
        w_bus_state = 1'b1;
        w_req_addr  = REG_TXBUSY;
        // Busy transmitter: stay here and poll again, without any timeout.
        if (w_complete) w_state_nxt = uart_rdata[0] ? S_TX_POLL : S_TX_WR;
      end
      S_TX_WR: begin
        w_bus_state = 1'b1;
        w_req_addr  = REG_TXDATA;
        w_req_wdata = {{(DATA_W-8){1'b0}}, r_tx_byte};
        w_req_wstrb = STRB_WR;
        if (w_complete) begin
          w_state_nxt     = S_IDLE;
          w_set_connected = r_tx_is_reply;
        end
      end
      S_RX_POLL: begin
        w_bus_state = 1'b1;
        w_req_addr  = REG_RXREADY;
        if (w_complete) w_state_nxt = uart_rdata[0] ? S_RX_RD : S_IDLE;
      end
      S_RX_RD: begin
        w_bus_state = 1'b1;
        w_req_addr  = REG_RXDATA;
        if (w_complete) begin
          w_latch_rx  = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_IDLE;
        case (r_rx_byte)
          CH_ENQ: begin
            w_evt_enq     = 1'b1;
            w_set_pending = ~r_enq_seen;
          end
          CH_EOT: begin
            w_set_done  = 1'b1;
            w_state_nxt = S_HALT;
          end
          CH_FRX:  w_evt_frx    = 1'b1;
          CH_FTX:  w_evt_ftx    = 1'b1;
          default: w_char_valid = 1'b1;
        endcase
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_INIT_DIV;
      end
    endcase
  end

  // Bus request register: launch, hold while waiting, drop after the answer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_issue) begin
      r_valid <= 1'b1;
      r_addr  <= w_req_addr;
      r_wdata <= w_req_wdata;
      r_wstrb <= w_req_wstrb;
    end else if (w_complete) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end
  end

  // Byte latches for the send and receive paths
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_byte     <= 8'h00;
      r_tx_is_reply <= 1'b0;
      r_rx_byte     <= 8'h00;
    end else begin
      if (w_sel_reply) begin
        r_tx_byte     <= REPLY_BYTE;
        r_tx_is_reply <= 1'b1;
      end else if (w_sel_tx) begin
        r_tx_byte     <= tx_data;
        r_tx_is_reply <= 1'b0;
      end
      if (w_latch_rx) r_rx_byte <= uart_rdata[7:0];
    end
  end

  // Reply bookkeeping and sticky status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending   <= 1'b0;
      r_enq_seen  <= 1'b0;
      r_done      <= 1'b0;
      r_connected <= 1'b0;
    end else begin
      if (w_set_pending) begin
        r_pending  <= 1'b1;
        r_enq_seen <= 1'b1;
      end else if (w_sel_reply) begin
        r_pending  <= 1'b0;
      end
      if (w_set_connected) r_connected <= 1'b1;
      if (w_set_done)      r_done      <= 1'b1;
    end
  end

  assign uart_valid  = r_valid;
  assign uart_addr   = r_addr;
  assign uart_wdata  = r_wdata;
  assign uart_wstrb  = r_wstrb;
  assign tx_ready    = w_sel_tx;
  assign char_valid  = w_char_valid;
  assign char_data   = w_char_valid ? r_rx_byte : 8'h00;
  assign evt_enq     = w_evt_enq;
  assign evt_frx     = w_evt_frx;
  assign evt_ftx     = w_evt_ftx;
  assign done        = r_done;
  assign connected   = r_connected;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_console_master.sv
// Testbench for uart_console_master: a bench-side UART slave answers bus
// requests with random latency; a reference model turns every stimulus into
// expected observable events; a monitor compares DUT outputs to that queue.
module tb_uart_console_master;

  localparam int DATA_W = 32;
  localparam int AW     = 3;
  localparam int DIV    = 434;
  localparam int W      = 40;

`ifdef CONSOLE_LD_FW_EN
  localparam logic [7:0] REPLY = 8'h07;
`else
  localparam logic [7:0] REPLY = 8'h06;
`endif

  // Event kinds: 8'h10|addr write, 20 char, 30 enq, 31 frx, 32 ftx,
  // 40 connected rises, 41 done rises, 50 tx_ready with byte
  logic              clk;
  logic              reset;
  logic              uart_valid;
  logic [AW-1:0]     uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic [3:0]        uart_wstrb;
  logic [DATA_W-1:0] uart_rdata;
  logic              uart_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              evt_enq;
  logic              evt_frx;
  logic              evt_ftx;
  logic              done;
  logic              connected;
  logic [3:0]        o_dbg_state;

  logic [W-1:0] exp_q[$];
  logic [7:0]   rx_q[$];
  int           checks = 0;
  int           failures = 0;
  int           busy_left = 0;
  int           txbusy_reads = 0;
  int           max_lat = 0;
  int           fixed_lat = -1;
  bit           first_read_pending = 0;
  bit           m_enq_seen = 0;
  bit           prev_conn = 0;
  bit           prev_done = 0;

  uart_console_master #(.DATA_W(DATA_W), .UART_ADDR_W(AW), .DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata), .uart_ready(uart_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .char_valid(char_valid), .char_data(char_data),
    .evt_enq(evt_enq), .evt_frx(evt_frx), .evt_ftx(evt_ftx),
    .done(done), .connected(connected), .o_dbg_state(o_dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input logic [7:0] kind, input logic [31:0] data);
    return {kind, data};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: what each received byte must produce
  task automatic model_rx(input logic [7:0] b);
    case (b)
      8'h05: begin
        exp_q.push_back(ev(8'h30, 0));
        if (!m_enq_seen) begin
          m_enq_seen = 1;
          exp_q.push_back(ev(8'h15, {24'h0, REPLY}));
          exp_q.push_back(ev(8'h40, 0));
        end
      end
      8'h04:   exp_q.push_back(ev(8'h41, 0));
      8'h07:   exp_q.push_back(ev(8'h31, 0));
      8'h08:   exp_q.push_back(ev(8'h32, 0));
      default: exp_q.push_back(ev(8'h20, {24'h0, b}));
    endcase
  endtask

  task automatic push_init();
    exp_q.push_back(ev(8'h10, DIV));
    exp_q.push_back(ev(8'h11, 1));
    exp_q.push_back(ev(8'h12, 1));
  endtask

  task automatic observe(input logic [W-1:0] o);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=%0h required=none at %0t", o, $time);
    end else begin
      check("event", o, exp_q.pop_front());
    end
  endtask

  // Monitor: turn DUT outputs into events and score them
  always @(negedge clk) begin
    if (reset) begin
      if (uart_valid && uart_ready && uart_wstrb != 4'h0)
        observe(ev({5'b00010, uart_addr}, uart_wdata));
      if (char_valid) observe(ev(8'h20, {24'h0, char_data}));
      if (evt_enq)    observe(ev(8'h30, 0));
      if (evt_frx)    observe(ev(8'h31, 0));
      if (evt_ftx)    observe(ev(8'h32, 0));
      if (connected && !prev_conn) observe(ev(8'h40, 0));
      if (done && !prev_done)      observe(ev(8'h41, 0));
      if (tx_ready)   observe(ev(8'h50, {24'h0, tx_data}));
      if (done) check("halt_quiet", {uart_valid, tx_ready}, 0);
      prev_conn = connected;
      prev_done = done;
    end else begin
      prev_conn = 0;
      prev_done = 0;
    end
  end

  // UART slave model: answers one request at a time
  logic [AW-1:0]     s_a;
  logic [DATA_W-1:0] s_d;
  logic [3:0]        s_s;
  int                s_lat;
  bit                s_abort;
  initial begin : responder
    uart_ready = 1'b0;
    uart_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset && uart_valid && !uart_ready) begin
        s_a = uart_addr; s_d = uart_wdata; s_s = uart_wstrb;
        check("wstrb", s_s, (s_a == 3 || s_a == 4 || s_a == 6) ? 4'h0 : 4'hF);
        if (s_s == 4'h0 && first_read_pending) begin
          check("first_read_rxready", s_a, 4);
          first_read_pending = 0;
        end
        s_lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, max_lat);
        s_abort = 0;
        for (int k = 0; k < s_lat; k++) begin
          @(posedge clk); #1;
          if (!reset) begin s_abort = 1; break; end
          check("req_stable", {uart_valid, uart_addr, uart_wdata, uart_wstrb}, {1'b1, s_a, s_d, s_s});
        end
        if (!s_abort) begin
          case (s_a)
            3'd3: begin
              txbusy_reads++;
              uart_rdata = {$urandom_range(0, 32'h7fff_ffff), busy_left > 0 ? 1'b1 : 1'b0};
              if (busy_left > 0) busy_left--;
            end
            3'd4: uart_rdata = {$urandom_range(0, 32'h7fff_ffff), rx_q.size() > 0 ? 1'b1 : 1'b0};
            3'd6: uart_rdata = {$urandom_range(0, 24'hff_ffff), rx_q.size() > 0 ? rx_q.pop_front() : 8'h00};
            default: uart_rdata = $urandom;
          endcase
          uart_ready = 1'b1;
          @(posedge clk); #1;
          uart_ready = 1'b0;
          uart_rdata = '0;
          if (reset) check("valid_drop", uart_valid, 0);
        end
      end
    end
  end

  task automatic wait_quiet();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rx_q.size() == 0) break;
    end
    check("quiet_timeout", {exp_q.size() != 0, rx_q.size() != 0}, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    exp_q.delete(); rx_q.delete();
    busy_left = 0; m_enq_seen = 0; tx_valid = 1'b0;
    check("reset_outputs", {uart_valid, uart_addr, uart_wdata, uart_wstrb, tx_ready, char_valid,
                            char_data, evt_enq, evt_frx, evt_ftx, done, connected}, 0);
    repeat (3) @(negedge clk);
    check("reset_hold", {uart_valid, done, connected, o_dbg_state}, 0);
    push_init();
    first_read_pending = 1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("first_req", {uart_valid, uart_addr, uart_wdata, uart_wstrb}, {1'b1, 3'd0, 32'(DIV), 4'hF});
    wait_quiet();
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_q.push_back(b);
    model_rx(b);
    wait_quiet();
  endtask

  task automatic send_tx(input logic [7:0] b, input int busy);
    bit got;
    busy_left = busy;
    txbusy_reads = 0;
    exp_q.push_back(ev(8'h50, {24'h0, b}));
    exp_q.push_back(ev(8'h15, {24'h0, b}));
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = b; got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_ready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("tx_ready_seen", got, 1);
    wait_quiet();
    check("txbusy_reads", txbusy_reads, busy + 1);
  endtask

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Main stimulus
  initial begin : driver
    bit found;
    logic [7:0] b;
    reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    do_reset();

    // Directed: first ENQ replies, second does not; characters; busy TX
    send_rx(8'h05);
    check("connected", connected, 1);
    send_rx(8'h05);
    send_rx(8'h48);
    send_rx(8'h69);
    send_rx(8'h07);
    send_rx(8'h08);
    send_tx(8'hA5, 3);

    // Slow slave: request fields must hold for the whole wait
    fixed_lat = 5;
    send_rx(8'h48);
    send_tx(8'h5A, 1);
    fixed_lat = -1;

    // Randomised traffic
    for (int it = 0; it < 16; it++) begin
      max_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) begin
        send_tx(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 5))
          0: b = 8'h05;
          1: b = 8'h07;
          2: b = 8'h08;
          default: begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h04) b = 8'h41;
          end
        endcase
        send_rx(b);
      end
    end
    max_lat = 0;

    // EOT halts everything for good
    send_rx(8'h04);
    check("done", done, 1);
    tx_valid = 1'b1; tx_data = 8'h55;
    rx_q.push_back(8'h41);
    repeat (40) @(negedge clk);
    check("halt_rx_untouched", rx_q.size(), 1);
    check("halt_state_stuck", {uart_valid, tx_ready, done}, 3'b001);
    tx_valid = 1'b0;
    do_reset();

    // Reset in the middle of a TXDATA write
    fixed_lat = 30;
    busy_left = 0;
    exp_q.push_back(ev(8'h50, 32'h3C));
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = 8'h3C;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_ready) break;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (uart_valid && uart_addr == 3'd5) begin found = 1; break; end
    end
    check("txdata_write_seen", found, 1);
    #2 reset = 1'b0;
    #1 check("reset_drop", uart_valid, 0);
    fixed_lat = -1;
    do_reset();

    // After reset the one-time reply is owed again
    send_rx(8'h05);
    check("connected_again", connected, 1);
    send_rx(8'h69);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_console_master.md
UART_CONSOLE_MASTER -- requirements
Module: uart_console_master

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the bus data width.
REQ-002 The block SHALL have parameter UART_ADDR_W, default 3, giving the UART register address width.
REQ-003 The block SHALL have parameter DIV, default 434, giving the baud divisor written at init.
REQ-004 The block SHALL have ports clk (input, 1, clock) then reset (input, 1), with one clock and reset asynchronous and active-low.
REQ-005 The block SHALL have ports uart_valid (output, 1), uart_addr (output, UART_ADDR_W), uart_wdata (output, DATA_W) and uart_wstrb (output, 4), forming the native bus request.
REQ-006 The block SHALL have ports uart_rdata (input, DATA_W) and uart_ready (input, 1), forming the native bus response.
REQ-007 The block SHALL have ports tx_valid (input, 1), tx_data (input, 8) and tx_ready (output, 1), an upstream byte-send handshake.
REQ-008 The block SHALL have ports char_valid (output, 1) and char_data (output, 8), a one-cycle pulse for each printable or other non-control byte.
REQ-009 The block SHALL have ports evt_enq, evt_frx and evt_ftx (output, 1 each), one-cycle pulses on receipt of the matching control byte.
REQ-010 The block SHALL have ports done (output, 1, sticky, set on EOT) and connected (output, 1, sticky, set after the first ENQ reply is written).

Function
REQ-011 Register offsets SHALL be: 0 DIV, 1 TXEN, 2 RXEN, 3 TXBUSY, 4 RXREADY, 5 TXDATA, 6 RXDATA.
REQ-012 Bus rules:
  - At most one access is outstanding at a time.
  - uart_valid, uart_addr, uart_wdata and uart_wstrb are held stable from assertion until the cycle uart_ready=1.
  - uart_valid deasserts the cycle after ready.
  - Reads use wstrb=0; writes use wstrb=4'hF.
  - uart_rdata is sampled only in the ready cycle.
REQ-013 State sequence SHALL be INIT_DIV -> INIT_TXEN -> INIT_RXEN -> IDLE. TXEN and RXEN are each written with value 1.
REQ-014 IDLE priority SHALL be: pending reply first, then tx_valid, then an RX poll.
REQ-015 Any byte to send SHALL follow TX_POLL (read TXBUSY, repeating until bit0=0) -> TX_WR (write TXDATA) -> IDLE.
REQ-016 The RX path SHALL follow RX_POLL (read RXREADY). If bit0=0 it returns to IDLE; if bit0=1 it goes RX_RD (read RXDATA) -> DECODE -> IDLE.
REQ-017 DECODE SHALL act on rdata[7:0] as follows:
  - ENQ (0x05): pulse evt_enq; on the first ENQ since reset, set a pending reply.
  - EOT (0x04): pulse evt_enq not at all; set done and enter HALT.
  - FRX (0x07): pulse evt_frx.
  - FTX (0x08): pulse evt_ftx.
  - Any other value: char_valid=1 with char_data=byte.
REQ-018 Each DECODE SHALL produce exactly one output pulse, one cycle after the RXDATA ready cycle.
REQ-019 tx_ready SHALL pulse for one cycle when tx_data is latched, in the IDLE cycle that selects it.
REQ-020 tx_valid asserted during INIT, HALT or any non-IDLE state SHALL wait without loss.
REQ-021 connected SHALL set in the TX_WR ready cycle of the ENQ reply.
REQ-022 HALT SHALL be terminal: uart_valid=0, tx_ready=0, and all inputs are ignored until reset.
REQ-023 ENQs after the first SHALL only pulse evt_enq and SHALL NOT trigger a further reply.
REQ-024 A TXBUSY poll SHALL restart the poll with no timeout while TXBUSY stays 1.

Reset
REQ-025 While reset=0, all outputs SHALL be 0, the state SHALL be INIT_DIV, and the pending reply and connected flags SHALL be cleared.
REQ-026 Reset asserted mid-transfer SHALL drop uart_valid immediately, abandon the access, and restart at INIT_DIV.
REQ-027 The first request SHALL be issued on the first clk edge after reset deasserts.

Configuration
REQ-028 Macro CONSOLE_LD_FW_EN SHALL select the ENQ reply byte:
  - Defined: the reply byte is FRX (0x07), requesting firmware upload.
  - Undefined: the reply byte is ACK (0x06).
  - In both cases the reply is sent once only.

Verification
REQ-029 Reset, then UART model always ready -> writes DIV=434, TXEN=1 and RXEN=1 in order, then RXREADY reads begin.
REQ-030 RX byte 0x05 -> evt_enq pulse, then TXDATA write of 0x06 (0x07 with CONSOLE_LD_FW_EN), then connected=1. A second 0x05 -> no new write.
REQ-031 RX bytes 'H' (0x48) then 'i' (0x69) -> two char_valid pulses with char_data 0x48 then 0x69.
REQ-032 tx_valid with 0xA5 while TXBUSY returns 1 three times -> four TXBUSY reads, one TXDATA write of 0xA5, and a single tx_ready pulse.
REQ-033 uart_ready delayed 5 cycles -> request fields stay stable throughout. RX byte 0x04 -> done=1, and from then on uart_valid=0 permanently.
REQ-034 reset=0 during a TXDATA write -> uart_valid=0 within the same cycle; after release the block restarts with the DIV write.
